// File: rtl/rv_writeback_scoreboard.sv
// rv_writeback_scoreboard: registers writeback beats into a one-cycle GPR write port and tracks per-warp register reservations to block RAW/WAW hazards at issue.
// Ports: clk/reset (async active-low); writeback_if_* beat input with ready; ibuffer_if_* issue request with ready;
// dispatch_ready downstream back-pressure; gpr_wr_* register-file write port; perf_stall_cycles hazard-stall counter; sb_error sticky protocol error.
module rv_writeback_scoreboard #(
  parameter int CORE_ID = 0,
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS = 64,
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS = 44,
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     writeback_if_valid,
  input  logic [UUID_BITS-1:0]     writeback_if_uuid,
  input  logic [NW_BITS-1:0]       writeback_if_wid,
  input  logic [NUM_THREADS-1:0]   writeback_if_tmask,
  input  logic [31:0]              writeback_if_PC,
  input  logic [NUM_THREADS*32-1:0] writeback_if_data,
  input  logic [NR_BITS-1:0]       writeback_if_rd,
  input  logic                     writeback_if_wb,
  input  logic                     writeback_if_eop,
  output logic                     writeback_if_ready,
  input  logic                     ibuffer_if_valid,
  input  logic [NW_BITS-1:0]       ibuffer_if_wid,
  input  logic [NR_BITS-1:0]       ibuffer_if_rd,
  input  logic [NR_BITS-1:0]       ibuffer_if_rs1,
  input  logic [NR_BITS-1:0]       ibuffer_if_rs2,
  input  logic [NR_BITS-1:0]       ibuffer_if_rs3,
  input  logic                     ibuffer_if_wb,
  output logic                     ibuffer_if_ready,
  input  logic                     dispatch_ready,
  output logic                     gpr_wr_en,
  output logic [NW_BITS-1:0]       gpr_wr_wid,
  output logic [NR_BITS-1:0]       gpr_wr_rd,
  output logic [NUM_THREADS-1:0]   gpr_wr_tmask,
  output logic [NUM_THREADS*32-1:0] gpr_wr_data,
  output logic [31:0]              perf_stall_cycles,
  output logic                     sb_error
);
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse, set_m, clr_m;
  logic [NUM_REGS-1:0] inuse_w;
  logic wr_cap, rel, rel_err, hazard, set_en;
  logic unused_dbg;
  assign unused_dbg = (^{writeback_if_uuid, writeback_if_PC}) ^ (CORE_ID != 0);
  assign wr_cap = writeback_if_valid && writeback_if_ready && writeback_if_wb && writeback_if_rd != '0;
  assign inuse_w = inuse[ibuffer_if_wid];
  // register 0 is never reserved, so sources/destination of r0 cannot hazard
  assign hazard = ibuffer_if_valid && (inuse_w[ibuffer_if_rs1] || inuse_w[ibuffer_if_rs2] || inuse_w[ibuffer_if_rs3] || (ibuffer_if_wb && inuse_w[ibuffer_if_rd]));
  assign ibuffer_if_ready = !hazard && dispatch_ready;
  assign set_en = ibuffer_if_valid && ibuffer_if_ready && ibuffer_if_wb && ibuffer_if_rd != '0;
  always_comb begin
    set_m = '0;
    clr_m = '0;
    set_m[ibuffer_if_wid][ibuffer_if_rd] = set_en;
    clr_m[gpr_wr_wid][gpr_wr_rd] = rel;
  end
  // releasing an idle bit, or colliding with a same-cycle set, is a protocol violation
  assign rel_err = rel && (!inuse[gpr_wr_wid][gpr_wr_rd] || (set_m & clr_m) != '0);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeback_if_ready <= 1'b0;
      gpr_wr_en <= 1'b0;
      gpr_wr_wid <= '0;
      gpr_wr_rd <= '0;
      gpr_wr_tmask <= '0;
      gpr_wr_data <= '0;
      rel <= 1'b0;
      inuse <= '0;
      perf_stall_cycles <= '0;
      sb_error <= 1'b0;
    end else begin
      writeback_if_ready <= 1'b1;
      gpr_wr_en <= wr_cap;
      rel <= wr_cap && writeback_if_eop;
      if (wr_cap) begin
        gpr_wr_wid <= writeback_if_wid;
        gpr_wr_rd <= writeback_if_rd;
        gpr_wr_tmask <= writeback_if_tmask;
        gpr_wr_data <= writeback_if_data;
      end
      // release lands at the edge closing the write cycle; set wins on collision
      inuse <= (inuse & ~clr_m) | set_m;
      if (hazard && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (rel_err) sb_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rv_writeback_scoreboard.sv
// tb_rv_writeback_scoreboard: directed stimulus with a GPR-write scoreboard and inline hazard/counter checks.
module tb_rv_writeback_scoreboard;
  localparam int NW = 2, NR = 6, NT = 4;
  typedef logic [NW+NR+NT+NT*32-1:0] wr_t;
  logic clk = 0, reset = 0;
  logic wv = 0, wwb = 0, weop = 0, wready;
  logic [43:0] wuuid = 44'h123;
  logic [NW-1:0] wwid = 0;
  logic [NT-1:0] wtmask = 0;
  logic [31:0] wpc = 32'h8000_0000;
  logic [NT*32-1:0] wdata = 0;
  logic [NR-1:0] wrd = 0;
  logic iv = 0, iwb = 0, iready, dready = 1;
  logic [NW-1:0] iwid = 0;
  logic [NR-1:0] ird = 0, irs1 = 0, irs2 = 0, irs3 = 0;
  logic gen, sb_error;
  logic [NW-1:0] gwid;
  logic [NR-1:0] grd;
  logic [NT-1:0] gtmask;
  logic [NT*32-1:0] gdata;
  logic [31:0] perf;
  wr_t exp_q[$];
  int checks = 0, errors = 0;
  rv_writeback_scoreboard dut (
    .clk(clk), .reset(reset),
    .writeback_if_valid(wv), .writeback_if_uuid(wuuid), .writeback_if_wid(wwid),
    .writeback_if_tmask(wtmask), .writeback_if_PC(wpc), .writeback_if_data(wdata),
    .writeback_if_rd(wrd), .writeback_if_wb(wwb), .writeback_if_eop(weop),
    .writeback_if_ready(wready),
    .ibuffer_if_valid(iv), .ibuffer_if_wid(iwid), .ibuffer_if_rd(ird),
    .ibuffer_if_rs1(irs1), .ibuffer_if_rs2(irs2), .ibuffer_if_rs3(irs3),
    .ibuffer_if_wb(iwb), .ibuffer_if_ready(iready), .dispatch_ready(dready),
    .gpr_wr_en(gen), .gpr_wr_wid(gwid), .gpr_wr_rd(grd), .gpr_wr_tmask(gtmask),
    .gpr_wr_data(gdata), .perf_stall_cycles(perf), .sb_error(sb_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset === 1'b1 && gen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL gpr_write: unexpected write wid=%0h rd=%0h", gwid, grd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({gwid, grd, gtmask, gdata} !== e) begin
          errors++;
          $display("FAIL gpr_write: got %h expected %h", {gwid, grd, gtmask, gdata}, e);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ib(input logic v, input logic [NW-1:0] w, input logic [NR-1:0] r, input logic [NR-1:0] s1, input logic [NR-1:0] s2, input logic [NR-1:0] s3, input logic wbf);
    iv = v; iwid = w; ird = r; irs1 = s1; irs2 = s2; irs3 = s3; iwb = wbf;
    #1;
  endtask
  task automatic wb_drive(input logic [NW-1:0] w, input logic [NR-1:0] r, input logic [NT-1:0] m, input logic [NT*32-1:0] d, input logic wbf, input logic eop, input logic exp_wr);
    wv = 1; wwid = w; wrd = r; wtmask = m; wdata = d; wwb = wbf; weop = eop;
    if (exp_wr) exp_q.push_back({w, r, m, d});
  endtask
  task automatic wb_beat(input logic [NW-1:0] w, input logic [NR-1:0] r, input logic [NT-1:0] m, input logic [NT*32-1:0] d, input logic wbf, input logic eop, input logic exp_wr);
    wb_drive(w, r, m, d, wbf, eop, exp_wr);
    tick();
    wv = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1;
    check("ready_cycle0", wready, 0);
    check("gpr_en_reset", gen, 0);
    check("perf_reset", perf, 0);
    check("sb_error_reset", sb_error, 0);
    ib(1, 1, 0, 5, 6, 7, 0);
    check("ib_ready_dispatch1", iready, 1);
    dready = 0;
    #1;
    check("ib_ready_dispatch0", iready, 0);
    tick();
    check("ready_cycle1", wready, 1);
    dready = 1;
    ib(1, 1, 5, 0, 0, 0, 1);
    check("issue_w1_rd5", iready, 1);
    tick();
    ib(1, 1, 0, 5, 0, 0, 0);
    check("raw_stall", iready, 0);
    repeat (3) tick();
    check("perf_after_3", perf, 3);
    iv = 0;
    wb_beat(1, 5, 4'hF, {4{32'hDEADBEEF}}, 1, 1, 1);
    ib(1, 1, 0, 5, 0, 0, 0);
    check("stall_during_write", iready, 0);
    tick();
    check("ready_after_release", iready, 1);
    tick();
    check("perf_after_release", perf, 4);
    ib(1, 2, 0, 1, 2, 3, 0);
    dready = 0;
    #1;
    check("dispatch_only_stall", iready, 0);
    tick();
    check("perf_no_dispatch_count", perf, 4);
    dready = 1;
    ib(1, 0, 5, 0, 0, 0, 1);
    tick();
    ib(1, 2, 0, 0, 5, 0, 0);
    check("cross_warp_free", iready, 1);
    ib(1, 0, 0, 0, 5, 0, 0);
    check("same_warp_stall", iready, 0);
    ib(0, 0, 0, 0, 0, 0, 0);
    ib(1, 3, 7, 0, 0, 0, 1);
    tick();
    iv = 0;
    wb_drive(3, 7, 4'h5, {32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004}, 1, 0, 1);
    tick();
    wb_drive(3, 7, 4'hA, {32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008}, 1, 1, 1);
    ib(1, 3, 0, 0, 0, 7, 0);
    check("two_beat_stall_a", iready, 0);
    tick();
    wv = 0;
    #1;
    check("two_beat_no_early_release", iready, 0);
    tick();
    check("two_beat_released", iready, 1);
    check("perf_two_beat", perf, 6);
    ib(1, 0, 0, 0, 0, 0, 1);
    check("rd0_issue", iready, 1);
    tick();
    check("rd0_no_reservation", iready, 1);
    ib(0, 0, 0, 0, 0, 0, 0);
    wb_beat(0, 0, 4'hF, {4{32'hCAFE_F00D}}, 1, 1, 0);
    wb_beat(1, 3, 4'hF, {4{32'hBAAD_F00D}}, 0, 1, 0);
    tick();
    check("no_error_rd0_wb0", sb_error, 0);
    wb_beat(0, 9, 4'h3, {4{32'h0000_0099}}, 1, 1, 1);
    check("error_not_yet", sb_error, 0);
    tick();
    check("error_unreserved_release", sb_error, 1);
    repeat (2) tick();
    check("error_sticky", sb_error, 1);
    ib(1, 1, 10, 0, 0, 0, 1);
    tick();
    ib(1, 1, 11, 0, 0, 0, 1);
    tick();
    ib(1, 1, 12, 0, 0, 0, 1);
    tick();
    ib(1, 1, 0, 10, 11, 12, 0);
    check("three_reserved", iready, 0);
    ib(0, 0, 0, 0, 0, 0, 0);
    wb_drive(1, 10, 4'hF, {4{32'h0BAD_0BAD}}, 1, 1, 0);
    tick();
    check("write_pending", gen, 1);
    reset = 0;
    #1;
    wv = 0;
    check("reset_drops_write", gen, 0);
    check("reset_ready", wready, 0);
    check("reset_error", sb_error, 0);
    check("reset_perf", perf, 0);
    repeat (2) tick();
    reset = 1;
    tick();
    ib(1, 1, 0, 10, 11, 12, 0);
    check("post_reset_clear", iready, 1);
    ib(1, 0, 5, 5, 0, 0, 1);
    check("post_reset_w0r5", iready, 1);
    ib(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("post_reset_perf", perf, 0);
    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
